// File: rtl/c17_pkg.sv
// Shared c17 definitions: vector width, checker FSM states and the golden c17 function.
package c17_pkg;

    localparam int unsigned C17_VEC_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    // Golden c17 response; vec = {N1,N2,N3,N6,N7}, result = {N22,N23}
    function automatic logic [1:0] c17_golden(input logic [C17_VEC_W-1:0] vec);
        logic n1, n2, n3, n6, n7;
        logic n10, n11, n16, n19;
        n1  = vec[4];
        n2  = vec[3];
        n3  = vec[2];
        n6  = vec[1];
        n7  = vec[0];
        n10 = ~(n1 & n3);
        n11 = ~(n3 & n6);
        n16 = ~(n2 & n11);
        n19 = ~(n11 & n7);
        return {~(n10 & n16), ~(n16 & n19)};
    endfunction

endpackage

// File: rtl/c17_golden_model.sv
// Combinational golden c17: applied vector in, expected N22/N23 out.
module c17_golden_model
    import c17_pkg::*;
(
    input  logic [C17_VEC_W-1:0] i_vec,
    output logic                 o_g22,
    output logic                 o_g23
);

    logic [1:0] w_gold;

    // Evaluate the shared golden function
    always_comb begin
        w_gold = c17_golden(i_vec);
    end

    assign o_g22 = w_gold[1];
    assign o_g23 = w_gold[0];

endmodule

// File: rtl/c17_response_checker.sv
// c17 response analyser: golden compare, saturating mismatch count,
// first-fail capture and MISR compaction of the DUT responses.
module c17_response_checker
    import c17_pkg::*;
#(
    parameter int unsigned    NUM_VECTORS = 32,
    parameter int unsigned    CNT_W       = 6,
    parameter int unsigned    SIG_W       = 16,
    parameter logic [SIG_W-1:0] SIG_POLY  = SIG_W'(16'h1021),
    parameter logic [SIG_W-1:0] SIG_SEED  = SIG_W'(16'hFFFF)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 vec_valid,
    output logic                 vec_ready,
    input  logic [C17_VEC_W-1:0] vec_in,
    input  logic                 dut_n22,
    input  logic                 dut_n23,
    output logic                 mismatch_pulse,
    output logic [CNT_W-1:0]     mismatch_count,
    output logic                 first_fail_valid,
    output logic [C17_VEC_W-1:0] first_fail_vec,
    output logic [SIG_W-1:0]     signature,
    output logic                 done
);

    localparam int unsigned ACC_W = $clog2(NUM_VECTORS + 1);
    localparam logic [ACC_W-1:0] LAST_IDX = ACC_W'(NUM_VECTORS - 1);

    chk_state_t             r_state;
    logic [ACC_W-1:0]       r_acc_cnt;
    logic                   r_vec_ready;

    logic                   r_s1_valid;
    logic                   r_s1_last;
    logic [C17_VEC_W-1:0]   r_s1_vec;
    logic                   r_s1_n22;
    logic                   r_s1_n23;
    logic                   r_s1_g22;
    logic                   r_s1_g23;

    logic                   r_mismatch_pulse;
    logic [CNT_W-1:0]       r_count;
    logic                   r_ff_valid;
    logic [C17_VEC_W-1:0]   r_ff_vec;
    logic [SIG_W-1:0]       r_sig;
    logic                   r_done;

    logic                   w_g22;
    logic                   w_g23;
    logic                   w_accept;
    logic                   w_s1_mis;

    c17_golden_model u_golden (
        .i_vec (vec_in),
        .o_g22 (w_g22),
        .o_g23 (w_g23)
    );

    // Accept only in RUN while ready; a start edge discards any same-cycle vector
    assign w_accept = vec_valid && r_vec_ready && (r_state == RUN) && !start;
    assign w_s1_mis = (r_s1_n22 != r_s1_g22) || (r_s1_n23 != r_s1_g23);

    // FSM, stage register, accept counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_acc_cnt        <= '0;
            r_vec_ready      <= 1'b0;
            r_s1_valid       <= 1'b0;
            r_s1_last        <= 1'b0;
            r_s1_vec         <= '0;
            r_s1_n22         <= 1'b0;
            r_s1_n23         <= 1'b0;
            r_s1_g22         <= 1'b0;
            r_s1_g23         <= 1'b0;
            r_mismatch_pulse <= 1'b0;
            r_count          <= '0;
            r_ff_valid       <= 1'b0;
            r_ff_vec         <= '0;
            r_sig            <= SIG_SEED;
            r_done           <= 1'b0;
        end else if (start) begin
            r_state          <= RUN;
            r_acc_cnt        <= '0;
            r_vec_ready      <= 1'b1;
            r_s1_valid       <= 1'b0;
            r_s1_last        <= 1'b0;
            r_mismatch_pulse <= 1'b0;
            r_count          <= '0;
            r_ff_valid       <= 1'b0;
            r_ff_vec         <= '0;
            r_sig            <= SIG_SEED;
            r_done           <= 1'b0;
        end else begin
            r_mismatch_pulse <= 1'b0;
            r_s1_valid       <= w_accept;

            if (w_accept) begin
                r_s1_vec  <= vec_in;
                r_s1_n22  <= dut_n22;
                r_s1_n23  <= dut_n23;
                r_s1_g22  <= w_g22;
                r_s1_g23  <= w_g23;
                r_s1_last <= (r_acc_cnt == LAST_IDX);
                r_acc_cnt <= r_acc_cnt + ACC_W'(1);
                if (r_acc_cnt == LAST_IDX) begin
                    r_vec_ready <= 1'b0;
                end
            end

            if (r_s1_valid) begin
                r_mismatch_pulse <= w_s1_mis;
                if (w_s1_mis) begin
                    if (!(&r_count)) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                    if (!r_ff_valid) begin
                        r_ff_valid <= 1'b1;
                        r_ff_vec   <= r_s1_vec;
                    end
                end
                r_sig <= {r_sig[SIG_W-2:0], 1'b0}
                       ^ (r_sig[SIG_W-1] ? SIG_POLY : '0)
                       ^ SIG_W'({r_s1_n22, r_s1_n23});
                if (r_s1_last) begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign vec_ready        = r_vec_ready;
    assign mismatch_pulse   = r_mismatch_pulse;
    assign mismatch_count   = r_count;
    assign first_fail_valid = r_ff_valid;
    assign first_fail_vec   = r_ff_vec;
    assign signature        = r_sig;
    assign done             = r_done;

endmodule

// File: tb/tb_c17_response_checker.sv
// Directed bench for c17_response_checker (main instance CNT_W=6, second instance CNT_W=2).
module tb_c17_response_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        vec_valid;
    logic [4:0]  vec_in;
    logic        dut_n22;
    logic        dut_n23;

    logic        vec_ready,  vec_ready2;
    logic        pulse,      pulse2;
    logic [5:0]  count;
    logic [1:0]  count2;
    logic        ffv,        ffv2;
    logic [4:0]  ffvec,      ffvec2;
    logic [15:0] sig,        sig2;
    logic        done,       done2;

    int n_checks = 0;
    int n_pass   = 0;

    // Bench model state
    logic [15:0] exp_sig;
    int          exp_cnt;
    logic        exp_ffv;
    logic [4:0]  exp_ffvec;
    logic        last_mis;

    c17_response_checker #(.NUM_VECTORS(32), .CNT_W(6)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid),
        .vec_ready(vec_ready), .vec_in(vec_in), .dut_n22(dut_n22), .dut_n23(dut_n23),
        .mismatch_pulse(pulse), .mismatch_count(count), .first_fail_valid(ffv),
        .first_fail_vec(ffvec), .signature(sig), .done(done)
    );

    c17_response_checker #(.NUM_VECTORS(32), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid),
        .vec_ready(vec_ready2), .vec_in(vec_in), .dut_n22(dut_n22), .dut_n23(dut_n23),
        .mismatch_pulse(pulse2), .mismatch_count(count2), .first_fail_valid(ffv2),
        .first_fail_vec(ffvec2), .signature(sig2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference c17 in sum-of-products form
    function automatic logic [1:0] ref_c17(input logic [4:0] v);
        logic nand36;
        nand36 = ~(v[2] & v[1]);
        return {(v[4] & v[2]) | (v[3] & nand36), nand36 & (v[3] | v[0])};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic a, input logic b);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, a, b};
    endfunction

    // Start a run and apply n_vec vectors (index i -> vec i), flipping responses per mask
    task automatic run_vectors(input int n_vec, input logic [31:0] f22, input logic [31:0] f23,
                               input bit gaps);
        int   i;
        int   guard;
        logic [1:0] g;
        logic cur_acc, cur_mis, prev_acc, prev_mis;
        @(negedge clk);
        start = 1'b1; vec_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        exp_sig = 16'hFFFF; exp_cnt = 0; exp_ffv = 1'b0; exp_ffvec = 5'd0;
        prev_acc = 1'b0; prev_mis = 1'b0;
        n_checks++;
        if (vec_ready !== 1'b1) $display("FAIL ready_after_start: got %b want 1", vec_ready);
        else n_pass++;
        i = 0; guard = 0;
        while (i < n_vec && guard < 200) begin
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                vec_valid = 1'b0; cur_acc = 1'b0; cur_mis = 1'b0;
            end else begin
                g = ref_c17(5'(i));
                vec_valid = 1'b1; vec_in = 5'(i);
                dut_n22 = g[1] ^ f22[i];
                dut_n23 = g[0] ^ f23[i];
                cur_acc = 1'b1;
                cur_mis = f22[i] | f23[i];
            end
            @(negedge clk);
            n_checks++;
            if (pulse !== (prev_acc & prev_mis))
                $display("FAIL pulse_timing idx %0d: got %b want %b", i, pulse, prev_acc & prev_mis);
            else n_pass++;
            if (cur_acc) begin
                exp_sig = misr_step(exp_sig, dut_n22, dut_n23);
                if (cur_mis) begin
                    exp_cnt++;
                    if (!exp_ffv) begin exp_ffv = 1'b1; exp_ffvec = 5'(i); end
                end
                i++;
            end
            prev_acc = cur_acc; prev_mis = cur_mis;
        end
        vec_valid = 1'b0;
        last_mis = prev_mis;
        n_checks++;
        if (guard >= 200) $display("FAIL run_budget: applied %0d of %0d vectors", i, n_vec);
        else n_pass++;
        if (n_vec == 32) begin
            n_checks++;
            if (done !== 1'b0 || vec_ready !== 1'b0)
                $display("FAIL last_accept_edge: done=%b ready=%b want done=0 ready=0", done, vec_ready);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if (done !== 1'b1 || pulse !== last_mis)
                $display("FAIL done_latency: done=%b pulse=%b want done=1 pulse=%b", done, pulse, last_mis);
            else n_pass++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if (vec_ready !== 1'b0 || pulse !== 1'b0 || count !== 6'd0 || ffv !== 1'b0 ||
            ffvec !== 5'd0 || sig !== 16'hFFFF || done !== 1'b0 || count2 !== 2'd0)
            $display("FAIL %s: ready=%b pulse=%b cnt=%0d ffv=%b ffvec=%b sig=%h done=%b cnt2=%0d want 0/0/0/0/00000/ffff/0/0",
                     tag, vec_ready, pulse, count, ffv, ffvec, sig, done, count2);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            vec_in = 5'($urandom); vec_valid = 1'($urandom); start = 1'($urandom);
            dut_n22 = 1'($urandom); dut_n23 = 1'($urandom);
        end
        #1;
        check_reset_values("reset_initial");
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0; vec_valid = 1'b0;
        run_vectors(5, 32'hFFFF_FFFF, 32'h0, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        vec_valid = 1'b1; vec_in = 5'h1F;
        #1;
        check_reset_values("reset_midcycle");
        @(negedge clk);
        rst_n = 1'b1; vec_valid = 1'b0;
    endtask

    task automatic test_clean_run;
        run_vectors(32, 32'h0, 32'h0, 1'b0);
        n_checks++;
        if (count !== 6'd0 || ffv !== 1'b0 || sig !== exp_sig)
            $display("FAIL clean_run: cnt=%0d ffv=%b sig=%h want 0/0/%h", count, ffv, sig, exp_sig);
        else n_pass++;
    endtask

    task automatic test_trojan;
        run_vectors(32, 32'h8000_0000, 32'h8000_0000, 1'b0);
        n_checks++;
        if (count !== 6'd1 || ffv !== 1'b1 || ffvec !== 5'b11111 || done !== 1'b1)
            $display("FAIL trojan: cnt=%0d ffv=%b ffvec=%b done=%b want 1/1/11111/1", count, ffv, ffvec, done);
        else n_pass++;
        n_checks++;
        if (sig !== exp_sig) $display("FAIL trojan_sig: got %h want %h", sig, exp_sig);
        else n_pass++;
    endtask

    task automatic test_multi_fail_gaps;
        run_vectors(32, 32'h0, 32'h0000_000A, 1'b1);
        n_checks++;
        if (count !== 6'd2 || ffv !== 1'b1 || ffvec !== 5'b00001)
            $display("FAIL multi_fail: cnt=%0d ffv=%b ffvec=%b want 2/1/00001", count, ffv, ffvec);
        else n_pass++;
        n_checks++;
        if (sig !== exp_sig) $display("FAIL multi_fail_sig: got %h want %h", sig, exp_sig);
        else n_pass++;
    endtask

    task automatic test_saturation_ignore;
        run_vectors(32, 32'hFFFF_FFFF, 32'h0, 1'b0);
        n_checks++;
        if (count2 !== 2'b11 || count !== 6'd32 || done2 !== 1'b1 || ffvec2 !== 5'd0)
            $display("FAIL saturation: cnt2=%0d cnt=%0d done2=%b ffvec2=%b want 3/32/1/00000",
                     count2, count, done2, ffvec2);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            vec_valid = 1'b1; vec_in = 5'(k + 3); dut_n22 = 1'b1; dut_n23 = 1'b1;
            @(negedge clk);
            n_checks++;
            if (pulse !== 1'b0 || pulse2 !== 1'b0 || done !== 1'b1 || count2 !== 2'b11 ||
                count !== 6'd32 || vec_ready !== 1'b0 || sig !== exp_sig)
                $display("FAIL done_ignore %0d: pulse=%b pulse2=%b done=%b cnt2=%0d cnt=%0d ready=%b sig=%h",
                         k, pulse, pulse2, done, count2, count, vec_ready, sig);
            else n_pass++;
        end
        vec_valid = 1'b0;
    endtask

    task automatic test_restart_abort;
        // (a) restart after 10 vectors; a vector presented on the start edge is dropped
        run_vectors(10, 32'h0000_0004, 32'h0, 1'b0);
        start = 1'b1; vec_valid = 1'b1; vec_in = 5'h1F; dut_n22 = 1'b0; dut_n23 = 1'b1;
        @(negedge clk);
        start = 1'b0; vec_valid = 1'b0;
        n_checks++;
        if (count !== 6'd0 || ffv !== 1'b0 || sig !== 16'hFFFF || done !== 1'b0 ||
            pulse !== 1'b0 || vec_ready !== 1'b1)
            $display("FAIL restart_clear: cnt=%0d ffv=%b sig=%h done=%b pulse=%b ready=%b",
                     count, ffv, sig, done, pulse, vec_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (pulse !== 1'b0 || count !== 6'd0)
            $display("FAIL restart_drop_vec: pulse=%b cnt=%0d want 0/0", pulse, count);
        else n_pass++;
        run_vectors(32, 32'h0, 32'h0, 1'b0);
        n_checks++;
        if (count !== 6'd0 || sig !== exp_sig)
            $display("FAIL restart_run: cnt=%0d sig=%h want 0/%h", count, sig, exp_sig);
        else n_pass++;
        // (b) reset abort after 10 vectors
        run_vectors(10, 32'h0000_0003, 32'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("abort_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            vec_valid = 1'b1; vec_in = 5'h1F; dut_n22 = 1'b0; dut_n23 = 1'b1;
            @(negedge clk);
        end
        vec_valid = 1'b0;
        check_reset_values("idle_ignore");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; vec_valid = 1'b0; vec_in = 5'd0;
        dut_n22 = 1'b0; dut_n23 = 1'b0; last_mis = 1'b0;
        exp_sig = 16'hFFFF; exp_cnt = 0; exp_ffv = 1'b0; exp_ffvec = 5'd0;
        test_reset();
        test_clean_run();
        test_trojan();
        test_multi_fail_gaps();
        test_saturation_ignore();
        test_restart_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
